rf_port_arbiter: RTL and testbench
==================================

// Module: rf_port_arbiter
// PURPOSE
//   Shares the register file's single write port (reg_write/wa/write_data) and single read port (ra/read_data) among NUM_REQ requesters.
//   Typical requesters: ALU writeback, I/O input loader, debug/boot loader.
//   Round-robin grant, valid/ready request handshake, two-stage pipeline (issue, response), one transaction per cycle.
//   Write-protected registers (R0 constant, R3 iszero flag) are rejected with an error response.
// PARAMETERS
//   NUM_REQ    3        number of requesters (2..8)
//   ADDR_W     4        register address width (16 registers)
//   DATA_W     16       register data width
//   PROT_MASK  16'h0009 bit i set => register i rejects arbiter writes
// PORTS
//   clock          in   1                  single system clock, rising edge
//   reset_n        in   1                  asynchronous, active-low reset
//   req_valid      in   NUM_REQ            per-requester request valid
//   req_ready      out  NUM_REQ            one-hot grant; transfer when valid&ready
//   req_write      in   NUM_REQ            1 = write, 0 = read
//   req_addr       in   NUM_REQ*ADDR_W     flattened; requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata      in   NUM_REQ*DATA_W     flattened write data, same packing
//   rsp_valid      out  NUM_REQ            one-hot, 1-cycle pulse to the originator
//   rsp_err        out  1                  qualifies rsp_valid: write to protected register
//   rsp_rdata      out  DATA_W             read data, qualifies rsp_valid on reads
//   rf_ra          out  ADDR_W             to register file read address
//   rf_read_data   in   DATA_W             from register file, combinational in rf_ra
//   rf_reg_write   out  1                  to register file write enable
//   rf_wa          out  ADDR_W             to register file write address
//   rf_write_data  out  DATA_W             to register file write data
// BEHAVIOUR
//   Reset: all registered outputs 0 (rsp_valid, rsp_err, rsp_rdata, rf_ra, rf_reg_write, rf_wa, rf_write_data); rr pointer = NUM_REQ-1.
//   Reset mid-operation discards in-flight transactions; no write reaches the RF after reset assertion.
//   Arbitration (cycle N):
//     - req_ready is combinational from req_valid and pointer; at most one bit set; never set without valid.
//     - Search order starts at pointer+1 (mod NUM_REQ); first valid requester wins.
//     - Pointer updates to the winner only when a grant occurs; it holds when no request is valid.
//     - Requester must hold valid/addr/data stable until ready; valid must not be withdrawn before ready.
//   Issue stage (cycle N+1, registered):
//     - Write, addr not in PROT_MASK: rf_reg_write=1, rf_wa=addr, rf_write_data=data; RF commits at end of N+1.
//     - Write, protected: rf_reg_write=0; error flag is carried to the response stage.
//     - Read: rf_ra=addr; rf_reg_write=0; rf_ra holds its value while idle.
//   Response stage (cycle N+2, registered):
//     - rsp_valid[id]=1 for one cycle.
//     - rsp_err=1 only for a protected write.
//     - rsp_rdata = rf_read_data sampled in N+1 for reads; 0 for writes.
//   Throughput: one grant per cycle sustained. Latency grant->response = 2 cycles.
//   Hazard: a write issued in N+1 is visible to a read issued in N+2; no forwarding needed.
//   Reads are allowed to protected addresses.
//   Other RF ports (iszero_write, in_data_write) are outside this block. Concurrent direct writes to R13 are the system's responsibility.
// STRUCTURE
//   Package rf_arb_pkg:
//     - ADDR_W, DATA_W, PROT_MASK defaults
//     - localparams REG_ZERO=0, REG_ISZERO=3, REG_IN=13, REG_OUT=14, REG_ACC=15
//     - struct/typedef for the issue-stage record {valid, id, write, addr, data}
//   Sub-module rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant, grant index, any_grant. Pure combinational; pointer register stays in the parent.
// TESTING
//   1. Reset release, req_valid=0 for 10 cycles -> req_ready=0, rf_reg_write=0, rsp_valid=0 throughout.
//   2. Req0 write addr 5 data 16'hBEEF -> ready[0] in N; N+1 rf_reg_write=1, rf_wa=5, rf_write_data=BEEF; N+2 rsp_valid=3'b001, rsp_err=0.
//   3. All three requesters valid continuously for 6 cycles -> grant order 0,1,2,0,1,2; pointer holds across an idle cycle, then resumes at next index.
//   4. Write addr 0 and write addr 3 -> rf_reg_write stays 0; rsp_err=1 at N+2. Read addr 3 -> rsp_err=0, data = RF[3].
//   5. Req1 write R7=16'h1234 granted N; req2 read R7 granted N+1 -> req2 rsp_rdata=16'h1234 at N+3.
//   6. Assert reset_n=0 in the cycle after a write grant -> no rf_reg_write pulse; all outputs 0; pointer back to NUM_REQ-1.

Source files
------------

// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package : rf_arb_pkg
//  Shared constants, the issue-stage record and a protection helper for the
//  register-file port arbiter.
//  Revision: 1.0  initial release
// ============================================================================
package rf_arb_pkg;

  // Default geometry of the register file served by the arbiter
  localparam int          DEF_ADDR_W    = 4;
  localparam int          DEF_DATA_W    = 16;
  localparam logic [15:0] DEF_PROT_MASK = 16'h0009;

  // Requester index width inside the issue record (covers up to 8 requesters)
  localparam int ID_W = 3;

  // Architectural register roles
  localparam int REG_ZERO   = 0;
  localparam int REG_ISZERO = 3;
  localparam int REG_IN     = 13;
  localparam int REG_OUT    = 14;
  localparam int REG_ACC    = 15;

  // One accepted transaction travelling from the issue to the response stage
  typedef struct packed {
    logic                  valid;
    logic [ID_W-1:0]       id;
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } iss_rec_t;

  // True when the addressed register refuses writes coming through the arbiter
  function automatic logic is_protected(input logic [(1<<DEF_ADDR_W)-1:0] mask,
                                        input logic [DEF_ADDR_W-1:0]      addr);
    return mask[addr];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Combinational round-robin picker: searches from ptr+1 (mod NUM_REQ) and
//  returns a one-hot grant, the winning index and an any-grant flag.
//  Revision: 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  int cand;

  // Walk the requesters once, starting just after the last winner
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_grant && req[cand[IDX_W-1:0]]) begin
        any_grant                = 1'b1;
        grant[cand[IDX_W-1:0]]   = 1'b1;
        grant_idx                = cand[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rf_port_arbiter
//  Shares the register file's single read and single write port among
//  NUM_REQ requesters: round-robin grant, registered issue stage driving the
//  RF, registered response stage returning data/error to the originator.
//  Revision: 1.0  initial release
// ============================================================================
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int                       NUM_REQ   = 3,
  parameter int                       ADDR_W    = DEF_ADDR_W,
  parameter int                       DATA_W    = DEF_DATA_W,
  parameter logic [(1<<ADDR_W)-1:0]   PROT_MASK = DEF_PROT_MASK
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic                        rsp_err,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [ADDR_W-1:0]           rf_ra,
  input  logic [DATA_W-1:0]           rf_read_data,
  output logic                        rf_reg_write,
  output logic [ADDR_W-1:0]           rf_wa,
  output logic [DATA_W-1:0]           rf_write_data
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Arbitration
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_grant;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  // Winning request fields
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Issue stage
  iss_rec_t           iss_q, iss_d;
  logic               rf_reg_write_q, rf_reg_write_d;
  logic [ADDR_W-1:0]  rf_ra_q, rf_ra_d;

  // Response stage
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign req_ready = grant;

  // Route the granted requester's command onto a single set of wires
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_data  = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state for pointer, issue stage and response stage
  always_comb begin
    // Pointer only moves on an actual grant
    ptr_d = any_grant ? grant_idx : ptr_q;

    // Issue stage captures the winner; payload holds while idle
    iss_d       = iss_q;
    iss_d.valid = any_grant;
    if (any_grant) begin
      iss_d.id    = ID_W'(grant_idx);
      iss_d.write = sel_write;
      iss_d.addr  = sel_addr;
      iss_d.data  = sel_data;
    end

    // Protected registers never see the write strobe
    rf_reg_write_d = any_grant && sel_write && !is_protected(PROT_MASK, sel_addr);

    // Read address is only retargeted by a read and otherwise holds
    rf_ra_d = (any_grant && !sel_write) ? sel_addr : rf_ra_q;

    // Response: pulse to the originator, error for rejected writes, data for reads
    rsp_valid_d = iss_q.valid ? (NUM_REQ'(1) << iss_q.id) : '0;
    rsp_err_d   = iss_q.valid && iss_q.write && is_protected(PROT_MASK, iss_q.addr);
    rsp_rdata_d = (iss_q.valid && !iss_q.write) ? rf_read_data : '0;
  end

  // Pipeline registers; reset drops any in-flight transaction
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q          <= IDX_W'(NUM_REQ - 1);
      iss_q          <= '0;
      rf_reg_write_q <= 1'b0;
      rf_ra_q        <= '0;
      rsp_valid_q    <= '0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
    end else begin
      ptr_q          <= ptr_d;
      iss_q          <= iss_d;
      rf_reg_write_q <= rf_reg_write_d;
      rf_ra_q        <= rf_ra_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_rdata_q    <= rsp_rdata_d;
    end
  end

  assign rf_reg_write  = rf_reg_write_q;
  assign rf_wa         = iss_q.addr;
  assign rf_write_data = iss_q.data;
  assign rf_ra         = rf_ra_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_rdata     = rsp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_rf_port_arbiter
//  Self-checking bench for rf_port_arbiter: vector table, hand sequences and
//  randomized traffic against a transaction-level reference model.
//  Revision: 1.0  initial release
// ============================================================================
module tb_rf_port_arbiter;

  localparam int NR = 3;
  localparam int AW = 4;
  localparam int DW = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     rsp_valid;
  logic              rsp_err;
  logic [DW-1:0]     rsp_rdata;
  logic [AW-1:0]     rf_ra;
  logic [DW-1:0]     rf_read_data;
  logic              rf_reg_write;
  logic [AW-1:0]     rf_wa;
  logic [DW-1:0]     rf_write_data;

  always #5 clock = ~clock;

  rf_port_arbiter dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_err       (rsp_err),
    .rsp_rdata     (rsp_rdata),
    .rf_ra         (rf_ra),
    .rf_read_data  (rf_read_data),
    .rf_reg_write  (rf_reg_write),
    .rf_wa         (rf_wa),
    .rf_write_data (rf_write_data)
  );

  // Register file attached to the arbiter (environment)
  logic [DW-1:0] rf [16];
  logic          boot;
  always @(posedge clock) begin
    if (boot) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'hA000 + 16'(i);
    end else if (rf_reg_write) begin
      rf[rf_wa] <= rf_write_data;
    end
  end
  assign rf_read_data = rf[rf_ra];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [DW-1:0] mem [16];
  int            m_ptr;
  bit            ei_v, ei_write;
  int            ei_id;
  logic [AW-1:0] ei_addr;
  logic [DW-1:0] ei_data, ei_rdata;
  bit            er_v, er_err;
  int            er_id;
  logic [DW-1:0] er_rdata;

  function automatic bit m_prot(input logic [AW-1:0] a);
    return (a == 4'd0) || (a == 4'd3);
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  // Compare this cycle's DUT outputs to the model, then advance the model
  task automatic model_step();
    int            w;
    logic [NR-1:0] eg;
    if (!reset_n) begin
      m_ptr = NR - 1; ei_v = 0; er_v = 0;
      return;
    end
    w  = rr_pick(m_ptr, req_valid);
    eg = (w >= 0) ? NR'(1 << w) : '0;
    chk("m_ready", 32'(req_ready), 32'(eg));
    chk("m_rf_we", 32'(rf_reg_write), 32'(ei_v && ei_write && !m_prot(ei_addr)));
    if (ei_v && ei_write && !m_prot(ei_addr)) begin
      chk("m_rf_wa", 32'(rf_wa), 32'(ei_addr));
      chk("m_rf_wd", 32'(rf_write_data), 32'(ei_data));
    end
    if (ei_v && !ei_write) chk("m_rf_ra", 32'(rf_ra), 32'(ei_addr));
    chk("m_rsp_valid", 32'(rsp_valid), er_v ? 32'(1 << er_id) : 32'd0);
    chk("m_rsp_err", 32'(rsp_err), 32'(er_v && er_err));
    if (er_v) chk("m_rsp_rdata", 32'(rsp_rdata), 32'(er_rdata));
    // advance: write commits at end of its issue cycle
    if (ei_v && ei_write && !m_prot(ei_addr)) mem[ei_addr] = ei_data;
    er_v     = ei_v;
    er_id    = ei_id;
    er_err   = ei_write && m_prot(ei_addr);
    er_rdata = ei_write ? '0 : ei_rdata;
    ei_v     = (w >= 0);
    if (w >= 0) begin
      ei_id    = w;
      ei_write = req_write[w];
      ei_addr  = req_addr[w*AW +: AW];
      ei_data  = req_wdata[w*DW +: DW];
      ei_rdata = mem[req_addr[w*AW +: AW]];
      m_ptr    = w;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    model_step();
  endtask

  task automatic clr();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[id]          = 1'b1;
    req_write[id]          = wr;
    req_addr[id*AW +: AW]  = a;
    req_wdata[id*DW +: DW] = d;
  endtask

  typedef struct {
    int            id;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            e_we;
    bit            e_err;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs [8];
  int   gseq [13];
  bit            pend [NR];
  bit            pw   [NR];
  logic [AW-1:0] pa   [NR];
  logic [DW-1:0] pd   [NR];

  initial begin
    vecs[0] = '{0, 1'b1, 4'd5,  16'hBEEF, 1'b1, 1'b0, 16'h0000};
    vecs[1] = '{1, 1'b1, 4'd0,  16'h1111, 1'b0, 1'b1, 16'h0000};
    vecs[2] = '{2, 1'b1, 4'd3,  16'h2222, 1'b0, 1'b1, 16'h0000};
    vecs[3] = '{0, 1'b0, 4'd3,  16'h0000, 1'b0, 1'b0, 16'hA003};
    vecs[4] = '{2, 1'b0, 4'd5,  16'h0000, 1'b0, 1'b0, 16'hBEEF};
    vecs[5] = '{1, 1'b0, 4'd0,  16'h0000, 1'b0, 1'b0, 16'hA000};
    vecs[6] = '{2, 1'b1, 4'd15, 16'hCAFE, 1'b1, 1'b0, 16'h0000};
    vecs[7] = '{1, 1'b0, 4'd15, 16'h0000, 1'b0, 1'b0, 16'hCAFE};
    gseq    = '{0, 1, 2, 0, 1, 2, -1, 0, 1, 2, 0, -1, 1};
    for (int i = 0; i < NR; i++) begin pend[i] = 0; pw[i] = 0; pa[i] = '0; pd[i] = '0; end
    for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
    m_ptr = NR - 1; ei_v = 0; er_v = 0; ei_write = 0; ei_id = 0; er_id = 0; er_err = 0;
    ei_addr = '0; ei_data = '0; ei_rdata = '0; er_rdata = '0;

    // ---- reset state ----
    boot = 1'b1;
    reset_n = 1'b0;
    clr();
    repeat (3) @(posedge clock);
    #1 boot = 1'b0;
    @(negedge clock);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rf_ra", 32'(rf_ra), 32'd0);
    chk("rst_rf_we", 32'(rf_reg_write), 32'd0);
    chk("rst_rf_wa", 32'(rf_wa), 32'd0);
    chk("rst_rf_wd", 32'(rf_write_data), 32'd0);
    next_cycle();
    reset_n = 1'b1;

    // ---- idle after reset ----
    for (int c = 0; c < 10; c++) begin
      if (c != 0) next_cycle();
      sample();
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_rf_we", 32'(rf_reg_write), 32'd0);
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    end

    // ---- vector table: one isolated transaction each ----
    for (int v = 0; v < 8; v++) begin
      next_cycle();
      clr();
      set_req(vecs[v].id, vecs[v].wr, vecs[v].addr, vecs[v].data);
      sample();
      chk("vec_ready", 32'(req_ready), 32'(1 << vecs[v].id));
      next_cycle();
      clr();
      sample();
      chk("vec_rf_we", 32'(rf_reg_write), 32'(vecs[v].e_we));
      if (vecs[v].e_we) begin
        chk("vec_rf_wa", 32'(rf_wa), 32'(vecs[v].addr));
        chk("vec_rf_wd", 32'(rf_write_data), 32'(vecs[v].data));
      end
      if (!vecs[v].wr) chk("vec_rf_ra", 32'(rf_ra), 32'(vecs[v].addr));
      next_cycle();
      sample();
      chk("vec_rsp_valid", 32'(rsp_valid), 32'(1 << vecs[v].id));
      chk("vec_rsp_err", 32'(rsp_err), 32'(vecs[v].e_err));
      chk("vec_rsp_rdata", 32'(rsp_rdata), 32'(vecs[v].e_rdata));
    end

    // ---- back-to-back write then read of the same register ----
    next_cycle();
    clr();
    set_req(1, 1'b1, 4'd7, 16'h1234);
    sample();
    chk("b2b_grant_w", 32'(req_ready), 32'b010);
    next_cycle();
    clr();
    set_req(2, 1'b0, 4'd7, 16'h0000);
    sample();
    chk("b2b_grant_r", 32'(req_ready), 32'b100);
    next_cycle();
    clr();
    sample();
    chk("b2b_rsp_w", 32'(rsp_valid), 32'b010);
    next_cycle();
    sample();
    chk("b2b_rsp_r", 32'(rsp_valid), 32'b100);
    chk("b2b_rdata", 32'(rsp_rdata), 32'h1234);

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 400; c++) begin
      next_cycle();
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1;
          pw[i]   = 1'($urandom_range(0, 1));
          pa[i]   = 4'($urandom_range(0, 15));
          pd[i]   = 16'($urandom);
        end
        req_valid[i]          = pend[i];
        req_write[i]          = pw[i];
        req_addr[i*AW +: AW]  = pa[i];
        req_wdata[i*DW +: DW] = pd[i];
      end
      sample();
      for (int i = 0; i < NR; i++)
        if (req_valid[i] && req_ready[i]) pend[i] = 0;
    end
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      clr();
      sample();
    end

    // ---- reset right after a write grant ----
    next_cycle();
    clr();
    set_req(0, 1'b1, 4'd5, 16'h5555);
    sample();
    chk("rr_grant", 32'(req_ready), 32'b001);
    #1 reset_n = 1'b0;
    clr();
    next_cycle();
    sample();
    chk("rr_rf_we", 32'(rf_reg_write), 32'd0);
    chk("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rr_rsp_err", 32'(rsp_err), 32'd0);
    chk("rr_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rr_rf_ra", 32'(rf_ra), 32'd0);
    chk("rr_rf_wa", 32'(rf_wa), 32'd0);
    chk("rr_rf_wd", 32'(rf_write_data), 32'd0);
    next_cycle();
    reset_n = 1'b1;
    sample();
    chk("rr_rf_untouched", 32'(rf[5]), 32'(mem[5]));

    // ---- all requesters continuously valid; pointer holds across idle ----
    for (int s = 0; s < 13; s++) begin
      next_cycle();
      clr();
      if (gseq[s] >= 0)
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 4'(8 + i), 16'h0000);
      sample();
      chk("rr_order", 32'(req_ready), (gseq[s] < 0) ? 32'd0 : 32'(1 << gseq[s]));
    end
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      clr();
      sample();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
